// File: rtl/i2c_slave_burst.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_burst
// Description : I2C target with a 1- or 2-byte register pointer, burst
//               read/write with optional pointer auto-increment, SCL/SDA
//               glitch filtering and a programmable SDA hold delay. Drives a
//               simple strobe-based register bus.
// Ports       : clk, rst        - system clock, synchronous active-high reset
//               scl_i, sda_i    - asynchronous bus pins
//               sda_o, sda_oe   - open-drain SDA drive (sda_oe=1 pulls low)
//               reg_addr        - register pointer
//               reg_wdata/reg_wr- write data and 1-clk write strobe
//               reg_rd/reg_rdata- 1-clk read strobe, data sampled next clk
//               busy, xfer_done - bus activity / end-of-transaction pulse
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_burst #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_AW     = 8,
    parameter int         FILTER_LEN = 3,
    parameter int         SDA_HOLD   = 4,
    parameter int         AUTO_INC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              xfer_done
);

    localparam int                c_FCW       = $clog2(FILTER_LEN + 1);
    localparam logic [c_FCW-1:0]  c_FCNT_MAX  = c_FCW'(FILTER_LEN - 1);
    localparam int                c_HCW       = $clog2(SDA_HOLD + 1);
    localparam logic [c_HCW-1:0]  c_HOLD_INIT = c_HCW'(SDA_HOLD - 1);
    localparam logic [1:0]        c_PTR_BYTES = 2'(REG_AW / 8);
    localparam logic [REG_AW-1:0] c_INC       = (AUTO_INC != 0) ? REG_AW'(1) : '0;

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_DEV_ADDR  = 4'd1;
    localparam logic [3:0] c_DEV_ACK   = 4'd2;
    localparam logic [3:0] c_PTR       = 4'd3;
    localparam logic [3:0] c_PTR_ACK   = 4'd4;
    localparam logic [3:0] c_WDATA     = 4'd5;
    localparam logic [3:0] c_WDATA_ACK = 4'd6;
    localparam logic [3:0] c_RDATA     = 4'd7;
    localparam logic [3:0] c_RDATA_ACK = 4'd8;
    localparam logic [3:0] c_IGNORE    = 4'd9;

    // Pin conditioning: index 0 = SCL, index 1 = SDA. Accepted values reset
    // to 1 (idle bus level).
    logic [1:0]       w_pin_in;
    logic [1:0]       r_sync1, r_sync2, r_filt, r_filt_d;
    logic [c_FCW-1:0] r_fcnt [2];

    assign w_pin_in = {sda_i, scl_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
        end else begin
            r_sync1  <= w_pin_in;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                // A new level is accepted only after FILTER_LEN consecutive
                // samples that differ from the currently accepted level.
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == c_FCNT_MAX) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
    assign w_sda      = r_filt[1];
    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
    assign w_start    = ~r_filt[1] & r_filt_d[1] & r_filt[0] & r_filt_d[0];
    assign w_stop     = r_filt[1] & ~r_filt_d[1] & r_filt[0] & r_filt_d[0];

    logic [3:0]        r_state, w_state_next;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [1:0]        r_ptr_cnt;
    logic [REG_AW-1:0] r_ptr, w_ptr_load;
    logic [7:0]        r_reg_wdata, w_rx_byte;
    logic              r_reg_wr, r_reg_rd, r_rd_pend, r_rd_lat;
    logic              r_rw, r_acked, r_busy, r_xfer_done;
    logic              r_sda_oe, r_hold_pend, w_oe_target;
    logic [c_HCW-1:0]  r_hold_cnt;
    logic              w_byte_done, w_addr_match;

    assign w_rx_byte    = {r_shift[6:0], w_sda};
    assign w_byte_done  = (r_bit_cnt == 4'd8);
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);

    // Pointer bytes arrive MSB first; each completed byte lands in its slot.
    if (REG_AW > 8) begin : g_ptr_multi
        always_comb begin
            w_ptr_load = r_ptr;
            if (r_ptr_cnt == 2'd0) w_ptr_load[REG_AW-1 -: 8] = w_rx_byte;
            else                   w_ptr_load[7:0]           = w_rx_byte;
        end
    end else begin : g_ptr_single
        assign w_ptr_load = w_rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_oe_target  = 1'b0;
        if (w_start) begin
            w_state_next = c_DEV_ADDR;
        end else if (w_stop) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_DEV_ADDR:  if (w_scl_fall && w_byte_done)
                                 w_state_next = w_addr_match ? c_DEV_ACK : c_IGNORE;
                c_DEV_ACK:   if (w_scl_fall) w_state_next = r_rw ? c_RDATA : c_PTR;
                c_PTR:       if (w_scl_fall && w_byte_done) w_state_next = c_PTR_ACK;
                c_PTR_ACK:   if (w_scl_fall)
                                 w_state_next = (r_ptr_cnt == c_PTR_BYTES) ? c_WDATA : c_PTR;
                c_WDATA:     if (w_scl_fall && w_byte_done) w_state_next = c_WDATA_ACK;
                c_WDATA_ACK: if (w_scl_fall) w_state_next = c_WDATA;
                c_RDATA:     if (w_scl_fall && w_byte_done) w_state_next = c_RDATA_ACK;
                // Master NACK ends the read burst right at the sampling edge.
                c_RDATA_ACK: if (w_scl_rise && w_sda) w_state_next = c_IGNORE;
                             else if (w_scl_fall)     w_state_next = c_RDATA;
                default:     ;
            endcase
        end
        // Level SDA should take once the hold delay after SCL fall expires.
        case (r_state)
            c_DEV_ACK, c_PTR_ACK, c_WDATA_ACK: w_oe_target = 1'b1;
            c_RDATA:                           w_oe_target = ~r_shift[7];
            default:                           w_oe_target = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ptr_cnt   <= '0;
            r_ptr       <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_lat    <= 1'b0;
            r_rw        <= 1'b0;
            r_acked     <= 1'b0;
            r_busy      <= 1'b0;
            r_xfer_done <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_hold_pend <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= r_rd_pend;
            r_rd_pend   <= 1'b0;
            r_rd_lat    <= r_reg_rd;
            r_xfer_done <= 1'b0;
            if (r_reg_wr) r_ptr <= r_ptr + c_INC;
            if (w_start || w_stop) begin
                r_bit_cnt   <= '0;
                r_sda_oe    <= 1'b0;
                r_hold_pend <= 1'b0;
                r_busy      <= w_start;
                if (w_stop) begin
                    r_xfer_done <= r_acked;
                    r_acked     <= 1'b0;
                end
            end else begin
                if (w_scl_rise) begin
                    case (r_state)
                        c_DEV_ADDR, c_PTR, c_WDATA: begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                        c_RDATA: r_bit_cnt <= r_bit_cnt + 4'd1;
                        default: ;
                    endcase
                    if (r_state == c_PTR && r_bit_cnt == 4'd7) begin
                        r_ptr     <= w_ptr_load;
                        r_ptr_cnt <= r_ptr_cnt + 2'd1;
                    end
                    if (r_state == c_WDATA && r_bit_cnt == 4'd7) begin
                        r_reg_wdata <= w_rx_byte;
                        r_reg_wr    <= 1'b1;
                    end
                    // Read strobe is issued one clk later so that it sees the
                    // already-advanced pointer after a master ACK.
                    if (r_state == c_DEV_ACK && r_rw) r_rd_pend <= 1'b1;
                    if (r_state == c_RDATA_ACK && !w_sda) begin
                        r_ptr     <= r_ptr + c_INC;
                        r_rd_pend <= 1'b1;
                    end
                end
                if (w_scl_fall) begin
                    if (w_byte_done) r_bit_cnt <= '0;
                    if (r_state == c_DEV_ADDR && w_byte_done) begin
                        r_rw      <= r_shift[0];
                        r_ptr_cnt <= '0;
                        if (w_addr_match) r_acked <= 1'b1;
                    end
                    if (r_state == c_RDATA && !w_byte_done) r_shift <= {r_shift[6:0], 1'b0};
                    r_hold_pend <= 1'b1;
                    r_hold_cnt  <= c_HOLD_INIT;
                end else if (r_hold_pend) begin
                    if (r_hold_cnt == '0) begin
                        r_hold_pend <= 1'b0;
                        r_sda_oe    <= w_oe_target;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
            end
            if (r_rd_lat) r_shift <= reg_rdata;
        end
    end

    assign sda_o     = 1'b0;
    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_ptr;
    assign reg_wdata = r_reg_wdata;
    assign reg_wr    = r_reg_wr;
    assign reg_rd    = r_reg_rd;
    assign busy      = r_busy;
    assign xfer_done = r_xfer_done;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_burst
// Description : Bit-banged I2C master driving i2c_slave_burst (REG_AW=16)
//               through an open-drain bus model, with a registered register
//               file model. Strobes and end-of-transaction pulses are checked
//               against queues of expected events by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_burst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_o, sda_oe, reg_wr, reg_rd, busy, xfer_done;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = 8'h00;
    logic [7:0]  mem [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_done[$];
    wr_t         mon_wr;
    logic [15:0] mon_a;
    logic        watch_release = 1'b0;
    int          oe_hits = 0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_burst #(
        .SLAVE_ADDR(7'h50), .REG_AW(16), .FILTER_LEN(3), .SDA_HOLD(4), .AUTO_INC(1)
    ) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line),
        .sda_o(sda_o), .sda_oe(sda_oe), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .busy(busy), .xfer_done(xfer_done)
    );

    always @(posedge clk) if (reg_rd) reg_rdata <= mem[reg_addr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: strobe seen, nothing expected (addr 0x%0h)", name, reg_addr);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (watch_release && sda_oe) oe_hits++;
            if (reg_wr) begin
                check("wr_rd_excl", {31'd0, reg_rd}, 32'd0);
                if (exp_wr.size() == 0) unexpected("reg_wr");
                else begin
                    mon_wr = exp_wr.pop_front();
                    check("wr_addr", {16'd0, reg_addr}, {16'd0, mon_wr.addr});
                    check("wr_data", {24'd0, reg_wdata}, {24'd0, mon_wr.data});
                end
            end
            if (reg_rd) begin
                if (exp_rd.size() == 0) unexpected("reg_rd");
                else begin
                    mon_a = exp_rd.pop_front();
                    check("rd_addr", {16'd0, reg_addr}, {16'd0, mon_a});
                end
            end
            if (xfer_done) begin
                if (exp_done.size() == 0) unexpected("xfer_done");
                else begin
                    mon_a = exp_done.pop_front();
                    check("done_ptr", {16'd0, reg_addr}, {16'd0, mon_a});
                end
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period: data set mid-low, sampled mid-high. With glitch set, an
    // SCL pulse is injected while low and (for a 1 bit) an SDA low pulse
    // while high, both shorter than the filter length.
    task automatic bit_cycle(input logic b, input logic glitch, output logic rx);
        wclk(10);
        sda_m = b;
        if (glitch) begin
            wclk(5); scl_m = 1'b1; wclk(2); scl_m = 1'b0; wclk(8);
        end else wclk(15);
        scl_m = 1'b1;
        wclk(10);
        rx = sda_line;
        if (glitch && b) begin
            sda_m = 1'b0; wclk(2); sda_m = 1'b1; wclk(8);
        end else wclk(10);
        scl_m = 1'b0;
    endtask

    task automatic do_start();
        sda_m = 1'b1; wclk(20);
        scl_m = 1'b1; wclk(20);
        sda_m = 1'b0; wclk(20);
        scl_m = 1'b0;
    endtask

    task automatic do_stop();
        sda_m = 1'b0; wclk(20);
        scl_m = 1'b1; wclk(20);
        sda_m = 1'b1; wclk(30);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gl, output logic ack);
        logic rx;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], gl, rx);
        bit_cycle(1'b1, 1'b0, rx);
        ack = ~rx;
    endtask

    task automatic send_ack(input string name, input logic [7:0] b, input logic gl);
        logic ack;
        send_byte(b, gl, ack);
        check(name, {31'd0, ack}, 32'd1);
    endtask

    task automatic recv_byte(input string name, input logic nack, input logic [7:0] exp);
        logic       rx;
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, 1'b0, rx);
            d = {d[6:0], rx};
        end
        bit_cycle(nack, 1'b0, rx);
        check(name, {24'd0, d}, {24'd0, exp});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ack;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[5] = 8'h11; mem[6] = 8'h22; mem[7] = 8'h33;
        mem[8] = 8'h0F; mem[9] = 8'hF0;

        // Reset state
        wclk(5);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_sda_o", {31'd0, sda_o}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, xfer_done}, 32'd0);
        check("rst_wr", {31'd0, reg_wr}, 32'd0);
        check("rst_rd", {31'd0, reg_rd}, 32'd0);
        check("rst_addr", {16'd0, reg_addr}, 32'd0);
        check("rst_wdata", {24'd0, reg_wdata}, 32'd0);
        rst = 1'b0;
        wclk(20);

        // Single write to 0x1234
        do_start();
        wclk(10);
        check("busy_start", {31'd0, busy}, 32'd1);
        exp_wr.push_back({16'h1234, 8'hAA});
        exp_done.push_back(16'h1235);
        send_ack("ack_addr_w", 8'hA0, 1'b0);
        send_ack("ack_ptr_hi", 8'h12, 1'b0);
        send_ack("ack_ptr_lo", 8'h34, 1'b0);
        send_ack("ack_data", 8'hAA, 1'b0);
        do_stop();
        check("busy_stop", {31'd0, busy}, 32'd0);

        // Burst write wrapping past 0xFFFF
        do_start();
        exp_done.push_back(16'h0002);
        send_ack("ack_b_addr", 8'hA0, 1'b0);
        send_ack("ack_b_ptr_hi", 8'hFF, 1'b0);
        send_ack("ack_b_ptr_lo", 8'hFE, 1'b0);
        exp_wr.push_back({16'hFFFE, 8'h01}); send_ack("ack_b_d0", 8'h01, 1'b0);
        exp_wr.push_back({16'hFFFF, 8'h02}); send_ack("ack_b_d1", 8'h02, 1'b0);
        exp_wr.push_back({16'h0000, 8'h03}); send_ack("ack_b_d2", 8'h03, 1'b0);
        exp_wr.push_back({16'h0001, 8'h04}); send_ack("ack_b_d3", 8'h04, 1'b0);
        do_stop();

        // Pointer write, repeated START, 3-byte burst read
        do_start();
        send_ack("ack_r_addr_w", 8'hA0, 1'b0);
        send_ack("ack_r_ptr_hi", 8'h00, 1'b0);
        send_ack("ack_r_ptr_lo", 8'h05, 1'b0);
        do_start();
        exp_rd.push_back(16'h0005);
        exp_rd.push_back(16'h0006);
        exp_rd.push_back(16'h0007);
        send_ack("ack_r_addr_r", 8'hA1, 1'b0);
        recv_byte("rd_byte0", 1'b0, 8'h11);
        recv_byte("rd_byte1", 1'b0, 8'h22);
        recv_byte("rd_byte2", 1'b1, 8'h33);
        wclk(15);
        check("sda_rel_nack", {31'd0, sda_oe}, 32'd0);
        exp_done.push_back(16'h0007);
        do_stop();

        // Foreign address 0x51, then a normal transaction
        watch_release = 1'b1;
        do_start();
        send_byte(8'hA2, 1'b0, ack);
        check("nack_addr51", {31'd0, ack}, 32'd0);
        send_byte(8'h12, 1'b0, ack);
        check("nack_data51", {31'd0, ack}, 32'd0);
        do_stop();
        watch_release = 1'b0;
        check("oe_during_51", oe_hits, 32'd0);
        do_start();
        exp_wr.push_back({16'h0010, 8'h5A});
        exp_done.push_back(16'h0011);
        send_ack("ack_n_addr", 8'hA0, 1'b0);
        send_ack("ack_n_ptr_hi", 8'h00, 1'b0);
        send_ack("ack_n_ptr_lo", 8'h10, 1'b0);
        send_ack("ack_n_data", 8'h5A, 1'b0);
        do_stop();

        // Sub-filter glitches on SCL and SDA
        do_start();
        exp_wr.push_back({16'h0020, 8'hC3});
        exp_done.push_back(16'h0021);
        send_ack("ack_g_addr", 8'hA0, 1'b0);
        send_ack("ack_g_ptr_hi", 8'h00, 1'b0);
        send_ack("ack_g_ptr_lo", 8'h20, 1'b1);
        send_ack("ack_g_data", 8'hC3, 1'b1);
        do_stop();

        // STOP after 4 data bits: partial byte discarded
        do_start();
        exp_done.push_back(16'h0030);
        send_ack("ack_p_addr", 8'hA0, 1'b0);
        send_ack("ack_p_ptr_hi", 8'h00, 1'b0);
        send_ack("ack_p_ptr_lo", 8'h30, 1'b0);
        bit_cycle(1'b1, 1'b0, ack);
        bit_cycle(1'b0, 1'b0, ack);
        bit_cycle(1'b1, 1'b0, ack);
        bit_cycle(1'b0, 1'b0, ack);
        do_stop();
        check("busy_partial", {31'd0, busy}, 32'd0);
        check("wdata_hold", {24'd0, reg_wdata}, 32'h0000_00C3);

        // Reset while the target drives a 0 data bit
        do_start();
        send_ack("ack_x_addr_w", 8'hA0, 1'b0);
        send_ack("ack_x_ptr_hi", 8'h00, 1'b0);
        send_ack("ack_x_ptr_lo", 8'h08, 1'b0);
        do_start();
        exp_rd.push_back(16'h0008);
        send_ack("ack_x_addr_r", 8'hA1, 1'b0);
        for (int i = 0; i < 40 && !sda_oe; i++) wclk(1);
        check("oe_drive0", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        wclk(1);
        check("oe_after_rst", {31'd0, sda_oe}, 32'd0);
        check("addr_after_rst", {16'd0, reg_addr}, 32'd0);
        rst = 1'b0;
        do_stop();
        check("busy_after_rst", {31'd0, busy}, 32'd0);

        // Full read after the reset
        do_start();
        send_ack("ack_y_addr_w", 8'hA0, 1'b0);
        send_ack("ack_y_ptr_hi", 8'h00, 1'b0);
        send_ack("ack_y_ptr_lo", 8'h08, 1'b0);
        do_start();
        exp_rd.push_back(16'h0008);
        exp_rd.push_back(16'h0009);
        send_ack("ack_y_addr_r", 8'hA1, 1'b0);
        recv_byte("rd_y_byte0", 1'b0, 8'h0F);
        recv_byte("rd_y_byte1", 1'b1, 8'hF0);
        exp_done.push_back(16'h0009);
        do_stop();

        wclk(50);
        check("wr_queue_left", exp_wr.size(), 32'd0);
        check("rd_queue_left", exp_rd.size(), 32'd0);
        check("done_queue_left", exp_done.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
